seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive stable cycles required before a digit is captured; legal range 2..255.
REQ-002 Parameter STALE_LIMIT, default 1048576: cycles without a completed frame before frame_valid drops.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 selector  input  4  scanned anode enables, active-low; bit k low selects digit k.
REQ-006 dispDigit  input  7  segment bus gfedcba, active-low.
REQ-007 d0, d1, d2, d3  output  4 each  decoded digit codes of the last complete frame.
REQ-008 frame_valid  output  1  high while a complete frame has been captured within STALE_LIMIT cycles.
REQ-009 frame_strobe  output  1  one-cycle pulse on each completed frame.
REQ-010 seg_err  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-011 sel_err  output  1  one-cycle pulse on capture of an illegal selector (two or more bits low).

Function
REQ-012 The block SHALL register selector and dispDigit into a sample stage (S1) every cycle.
REQ-013 Stability counter SHALL clear to 0 on an edge where S1 loads a value differing from its previous value, and otherwise increment, saturating at SETTLE.
REQ-014 A capture SHALL occur exactly once per dwell, on the edge where the stability counter goes from SETTLE-1 to SETTLE.
REQ-015 Selector 1111 at capture SHALL be treated as idle: no capture effect, no error, no FSM change.
REQ-016 Illegal selector at capture SHALL pulse sel_err and return the FSM to IDLE without updating outputs.
REQ-017 Decode SHALL map 1000000..0010000 (standard 0-9, active-low) to 0-9, 0111111 (dash) to 4'hA, 1111111 (blank) to 4'hB, and any other pattern to 4'hE with a seg_err pulse.
REQ-018 The frame FSM SHALL have states IDLE, EXP1, EXP2, EXP3; a digit-0 capture in any state SHALL store the code into shadow slot 0 and enter EXP1.
REQ-019 A digit-k capture in state EXPk (k=1,2) SHALL store into shadow slot k and advance to EXP(k+1).
REQ-020 A digit-3 capture in EXP3 SHALL, on that same edge, load d0..d3 from the shadow slots plus the new code, assert frame_strobe for one cycle, set frame_valid, and enter IDLE.
REQ-021 Any out-of-order capture (digit k not 0 and not expected) SHALL enter IDLE with d0..d3 unchanged and no strobe.
REQ-022 d0..d3 SHALL update only atomically per REQ-020; partial frames SHALL never be visible.
REQ-023 The stale counter SHALL clear on frame_strobe and otherwise increment, saturating; upon reaching STALE_LIMIT it SHALL clear frame_valid while d0..d3 hold.
REQ-024 A seg_err or 4'hE code SHALL NOT break frame ordering; the 4'hE code is stored normally.
REQ-025 Latency: an input change applied before edge e0 is captured at edge e0+SETTLE; an input change before that edge restarts the wait.

Reset
REQ-026 RESET high SHALL immediately force: d0..d3 = 4'hB, frame_valid = 0, frame_strobe = 0, seg_err = 0, sel_err = 0, FSM = IDLE, counters = 0, S1 = selector 1111 / segments 1111111.
REQ-027 RESET asserted mid-frame SHALL discard all shadow slots; the first frame after release SHALL start from a digit-0 capture.

Verification
REQ-028 Scan 1110/1000000, 1101/1111001, 1011/0100100, 0111/0110000, 8 cycles each, SETTLE=4 -> one frame_strobe 4 edges after digit-3 pattern; d0..d3 = 0,1,2,3; frame_valid = 1.
REQ-029 Glitch of 2 cycles inside a dwell, SETTLE=4 -> no extra capture, no error; outputs unchanged.
REQ-030 Out-of-order scan digit 0 then digit 2 -> no strobe, d0..d3 hold; following full ordered frame -> strobe and correct update.
REQ-031 Digit 1 presents 1010101, full frame -> seg_err pulse once; d1 = 4'hE; frame_strobe still asserts; selector 1001 dwell -> sel_err pulse, FSM to IDLE.
REQ-032 STALE_LIMIT=64: one frame, then selector held at 1111 -> frame_valid drops 64 cycles after strobe, d0..d3 retained.
REQ-033 RESET pulsed during EXP2 -> outputs return to reset values asynchronously; next ordered frame produces correct digits.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Recovers the four digits shown on a multiplexed, active-low 7-segment
// display by watching its anode enables and its shared segment bus.
// Once a selector/segment pair has been stable for SETTLE cycles, it is
// captured. A frame is accepted only when digits 0,1,2,3 are captured in
// that order. The four results are then published together.
//
// Ports
//   CLK           clock, rising edge
//   RESET         asynchronous, active-high reset
//   selector[3:0] anode enables, active-low (bit k low selects digit k)
//   dispDigit[6:0]segment bus gfedcba, active-low
//   d0..d3[3:0]   digit codes of the last complete frame
//                 0-9 digit, A dash, B blank, E undecodable
//   frame_valid   a frame has completed within the last STALE_LIMIT cycles
//   frame_strobe  one-cycle pulse when a frame completes
//   seg_err       one-cycle pulse when an undecodable pattern is captured
//   sel_err       one-cycle pulse when an illegal selector is captured
module seg_scan_decoder #(
  parameter int SETTLE      = 4,
  parameter int STALE_LIMIT = 1048576
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] selector,
  input  logic [6:0] dispDigit,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       frame_valid,
  output logic       frame_strobe,
  output logic       seg_err,
  output logic       sel_err
);

  localparam int SW = $clog2(STALE_LIMIT + 1);
  localparam logic [7:0]    SETTLE_MAX = 8'(SETTLE);
  localparam logic [7:0]    SETTLE_PRE = 8'(SETTLE - 1);
  localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_LIMIT);
  localparam logic [SW-1:0] STALE_PRE  = SW'(STALE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, EXP1, EXP2, EXP3} state_t;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111111: code = 4'hA;
      7'b1111111: code = 4'hB;
      default:    code = 4'hE;
    endcase
    return code;
  endfunction

  logic [3:0] sel_p0;
  logic [6:0] seg_p0;
  logic [7:0] cnt_p0;
  logic       chg;
  logic       cap_vld_p0;

  state_t     state, state_nxt;
  logic [1:0] dig_idx;
  logic       sel_idle, sel_bad;
  logic [3:0] code;
  logic       code_bad;
  logic [2:0] sh_we;
  logic       commit, seg_err_nxt, sel_err_nxt;
  logic [3:0] sh0, sh1, sh2;
  logic [SW-1:0] stale;

  // ---- stage 0: input sample and stability counter ----
  assign chg = ({selector, dispDigit} != {sel_p0, seg_p0});
  // The counter passes SETTLE-1 -> SETTLE only once per dwell, so this
  // event fires once per stable value. It fires on the edge where the
  // sampled value is still current.
  assign cap_vld_p0 = !chg && (cnt_p0 == SETTLE_PRE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_p0 <= 4'hF;
      seg_p0 <= 7'h7F;
      cnt_p0 <= 8'd0;
    end else begin
      sel_p0 <= selector;
      seg_p0 <= dispDigit;
      if (chg)
        cnt_p0 <= 8'd0;
      else if (cnt_p0 != SETTLE_MAX)
        cnt_p0 <= cnt_p0 + 8'd1;
    end
  end

  // ---- stage 1: capture decode, frame FSM, published outputs ----
  always_comb begin
    dig_idx  = 2'd0;
    sel_idle = 1'b0;
    sel_bad  = 1'b0;
    case (sel_p0)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      4'b1111: sel_idle = 1'b1;
      default: sel_bad  = 1'b1;
    endcase
  end

  assign code     = seg_decode(seg_p0);
  assign code_bad = (code == 4'hE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cap_vld_p0 && !sel_idle) begin
      if (sel_bad)                              state_nxt = IDLE;
      else if (dig_idx == 2'd0)                 state_nxt = EXP1;
      else if (dig_idx == 2'd1 && state == EXP1) state_nxt = EXP2;
      else if (dig_idx == 2'd2 && state == EXP2) state_nxt = EXP3;
      else                                      state_nxt = IDLE;
    end
  end

  always_comb begin
    sh_we       = 3'b000;
    commit      = 1'b0;
    seg_err_nxt = 1'b0;
    sel_err_nxt = 1'b0;
    if (cap_vld_p0 && !sel_idle) begin
      if (sel_bad) begin
        sel_err_nxt = 1'b1;
      end else begin
        seg_err_nxt = code_bad;
        if (dig_idx == 2'd0)                      sh_we[0] = 1'b1;
        else if (dig_idx == 2'd1 && state == EXP1) sh_we[1] = 1'b1;
        else if (dig_idx == 2'd2 && state == EXP2) sh_we[2] = 1'b1;
        else if (dig_idx == 2'd3 && state == EXP3) commit   = 1'b1;
      end
    end
  end

  // Shadow slots are gated by the FSM, which reset forces to IDLE,
  // so stale slot contents can never reach the outputs.
  always_ff @(posedge CLK) begin
    if (sh_we[0]) sh0 <= code;
    if (sh_we[1]) sh1 <= code;
    if (sh_we[2]) sh2 <= code;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      d0           <= 4'hB;
      d1           <= 4'hB;
      d2           <= 4'hB;
      d3           <= 4'hB;
      frame_strobe <= 1'b0;
      seg_err      <= 1'b0;
      sel_err      <= 1'b0;
      frame_valid  <= 1'b0;
      stale        <= '0;
    end else begin
      frame_strobe <= commit;
      seg_err      <= seg_err_nxt;
      sel_err      <= sel_err_nxt;
      if (commit) begin
        d0          <= sh0;
        d1          <= sh1;
        d2          <= sh2;
        d3          <= code;
        frame_valid <= 1'b1;
        stale       <= '0;
      end else if (stale != STALE_MAX) begin
        stale <= stale + 1'b1;
        if (stale == STALE_PRE)
          frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int STALE  = 64;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] selector;
  logic [6:0] dispDigit;
  logic [3:0] d0, d1, d2, d3;
  logic       frame_valid, frame_strobe, seg_err, sel_err;

  seg_scan_decoder #(.SETTLE(SETTLE), .STALE_LIMIT(STALE)) dut (
    .CLK(CLK), .RESET(RESET), .selector(selector), .dispDigit(dispDigit),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .frame_valid(frame_valid), .frame_strobe(frame_strobe),
    .seg_err(seg_err), .sel_err(sel_err)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [3:0] SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe, n_segerr, n_selerr, last_strobe_cyc;

  // Reference model state: abstract view of the scan protocol.
  logic [3:0] m_d [4];
  logic [3:0] m_sh [3];
  logic       m_valid, m_strobe, m_segerr, m_selerr, m_had;
  int         m_next;       // digit index the frame expects next (0 = none yet)
  logic [10:0] m_last;      // value currently held on the inputs
  int         m_age;        // consecutive edges the value has been present
  int         m_since;      // edges since last completed frame

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [6:0] seg);
    for (int i = 0; i < 10; i++)
      if (PAT[i] == seg) return {1'b0, 4'(i)};
    if (seg == 7'h3F) return {1'b0, 4'hA};
    if (seg == 7'h7F) return {1'b0, 4'hB};
    return {1'b1, 4'hE};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_d[i] = 4'hB;
    m_valid = 0; m_strobe = 0; m_segerr = 0; m_selerr = 0; m_had = 0;
    m_next = 0; m_last = {4'hF, 7'h7F}; m_age = 1; m_since = 0;
  endtask

  task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg);
    int zeros, k;
    logic [4:0] dc;
    m_strobe = 0; m_segerr = 0; m_selerr = 0;
    if ({sel, seg} == m_last) begin
      if (m_age < 1000) m_age++;
    end else begin
      m_last = {sel, seg}; m_age = 1;
    end
    if (m_since < 1000) m_since++;
    if (m_age == SETTLE + 1 && sel != 4'hF) begin
      zeros = 0; k = 0;
      for (int b = 0; b < 4; b++) if (!sel[b]) begin zeros++; k = b; end
      if (zeros != 1) begin
        m_selerr = 1; m_next = 0;
      end else begin
        dc = ref_dec(seg);
        m_segerr = dc[4];
        if (k == 0) begin
          m_sh[0] = dc[3:0]; m_next = 1;
        end else if (k == m_next && k < 3) begin
          m_sh[k] = dc[3:0]; m_next = k + 1;
        end else if (k == 3 && m_next == 3) begin
          m_d[0] = m_sh[0]; m_d[1] = m_sh[1]; m_d[2] = m_sh[2]; m_d[3] = dc[3:0];
          m_strobe = 1; m_had = 1; m_since = 0; m_next = 0;
        end else begin
          m_next = 0;
        end
      end
    end
    m_valid = m_had && (m_since < STALE);
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      selector = sel; dispDigit = seg;
      @(posedge CLK);
      cyc++;
      model_edge(sel, seg);
      #1;
      chk("model", {12'd0, d0, d1, d2, d3, frame_valid, frame_strobe, seg_err, sel_err},
          {12'd0, m_d[0], m_d[1], m_d[2], m_d[3], m_valid, m_strobe, m_segerr, m_selerr});
      if (frame_strobe) begin n_strobe++; last_strobe_cyc = cyc; end
      if (seg_err) n_segerr++;
      if (sel_err) n_selerr++;
    end
  endtask

  task automatic frame(input int a, input int b, input int c, input int d, input int n);
    step(SEL[0], PAT[a], n); step(SEL[1], PAT[b], n);
    step(SEL[2], PAT[c], n); step(SEL[3], PAT[d], n);
  endtask

  task automatic clr_tally();
    n_strobe = 0; n_segerr = 0; n_selerr = 0;
  endtask

  function automatic logic [15:0] dvec();
    return {d0, d1, d2, d3};
  endfunction

  initial begin
    int e0, s, sl;
    logic [3:0] rs;
    logic [6:0] rg;
    RESET = 1; selector = 4'hF; dispDigit = 7'h7F;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_vals", {dvec(), frame_valid, frame_strobe, seg_err, sel_err}, {16'hBBBB, 4'b0});
    RESET = 0;
    model_reset();
    step(4'hF, 7'h7F, 6);

    // Basic ordered frame, 8-cycle dwells
    clr_tally();
    step(SEL[0], PAT[0], 8); step(SEL[1], PAT[1], 8); step(SEL[2], PAT[2], 8);
    e0 = cyc + 1;
    step(SEL[3], PAT[3], 8);
    chk("frame_digits", dvec(), 16'h0123);
    chk("frame_valid", frame_valid, 1);
    chk("frame_strobe_cnt", n_strobe, 1);
    chk("strobe_latency", last_strobe_cyc - e0, SETTLE);

    // Glitch inside digit-1 dwell
    clr_tally();
    step(SEL[0], PAT[5], 8);
    step(SEL[1], PAT[6], 6); step(SEL[1], 7'h00, 2); step(SEL[1], PAT[6], 3);
    step(SEL[2], PAT[7], 8); step(SEL[3], PAT[8], 8);
    chk("glitch_digits", dvec(), 16'h5678);
    chk("glitch_strobe_cnt", n_strobe, 1);
    chk("glitch_err_cnt", n_segerr + n_selerr, 0);

    // Out-of-order: digit 0 then digit 2
    clr_tally();
    step(SEL[0], PAT[1], 8); step(SEL[2], PAT[1], 8); step(SEL[3], PAT[1], 8);
    chk("ooo_strobe_cnt", n_strobe, 0);
    chk("ooo_hold", dvec(), 16'h5678);
    frame(9, 0, 1, 2, 7);
    chk("ooo_recover", dvec(), 16'h9012);
    chk("ooo_recover_strobe", n_strobe, 1);

    // Undecodable pattern on digit 1, then illegal selector
    clr_tally();
    step(SEL[0], PAT[3], 8); step(SEL[1], 7'b1010101, 8);
    step(SEL[2], PAT[4], 8); step(SEL[3], PAT[5], 8);
    chk("segerr_cnt", n_segerr, 1);
    chk("segerr_digits", dvec(), 16'h3E45);
    chk("segerr_strobe", n_strobe, 1);
    clr_tally();
    step(SEL[0], PAT[6], 8); step(4'b1001, PAT[1], 8);
    step(SEL[1], PAT[1], 8); step(SEL[2], PAT[1], 8); step(SEL[3], PAT[1], 8);
    chk("selerr_cnt", n_selerr, 1);
    chk("selerr_no_strobe", n_strobe, 0);
    chk("selerr_hold", dvec(), 16'h3E45);

    // Stale timeout
    step(SEL[0], PAT[4], 8); step(SEL[1], PAT[5], 8); step(SEL[2], PAT[6], 8);
    step(SEL[3], PAT[7], SETTLE + 1);
    chk("stale_strobe", frame_strobe, 1);
    for (int i = 1; i <= 70; i++) begin
      step(4'hF, 7'h7F, 1);
      if (i == STALE - 1) chk("stale_before", frame_valid, 1);
      if (i == STALE)     chk("stale_drop", frame_valid, 0);
    end
    chk("stale_hold", dvec(), 16'h4567);

    // Reset while expecting digit 2
    step(SEL[0], PAT[1], 8); step(SEL[1], PAT[2], 8); step(SEL[2], PAT[3], 3);
    RESET = 1;
    #1;
    chk("async_reset", {dvec(), frame_valid, frame_strobe, seg_err, sel_err}, {16'hBBBB, 4'b0});
    RESET = 0;
    model_reset();
    clr_tally();
    step(SEL[3], PAT[3], 8);
    frame(9, 8, 7, 6, 8);
    chk("post_reset_digits", dvec(), 16'h9876);
    chk("post_reset_strobe", n_strobe, 1);

    // Randomized scan traffic against the model
    s = 0;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        8:       rs = SEL[$urandom_range(0, 3)];
        9:       rs = 4'($urandom);
        default: begin rs = SEL[s]; s = (s + 1) % 4; end
      endcase
      case ($urandom_range(0, 9))
        7:       rg = 7'h3F;
        8:       rg = 7'h7F;
        9:       rg = 7'($urandom);
        default: rg = PAT[$urandom_range(0, 9)];
      endcase
      sl = $urandom_range(1, 10);
      step(rs, rg, sl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
